// File: rtl/dense_ctrl_pkg.sv
// Shared types and default dimensions for the dense-layer sequencer.
package dense_ctrl_pkg;

    localparam int N_IN_DEF    = 32;
    localparam int N_OUT_DEF   = 5;
    localparam int MAC_LAT_DEF = 2;
    localparam int ROW_W       = $clog2(N_IN_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        HOLD  = 3'd4
    } state_e;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_row_counter.sv
// Loadable up-counter that saturates at a programmable terminal value.
module dense_row_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == last);

    // Increment is gated by tc so the count never wraps past the terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !tc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dense_seq_ctrl.sv
// Sequencer for a time-multiplexed dense layer: issues one MAC row per cycle,
// waits out the MAC pipeline, pulses bias add and presents the result downstream.
module dense_seq_ctrl
    import dense_ctrl_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    localparam int RW     = cnt_w(N_IN),
    localparam int DW     = cnt_w(MAC_LAT)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [RW-1:0] row_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          bias_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    state_e        state;
    state_e        nxt;
    logic          row_tc;
    logic [DW-1:0] drn_cnt;
    logic          drn_tc;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready) nxt = ACCUM;
            ACCUM:   if (row_tc) nxt = DRAIN;
            DRAIN:   if (drn_tc) nxt = BIAS;
            BIAS:    nxt = HOLD;
            HOLD:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    // Row index doubles as the registered row_addr output; it parks at N_IN-1
    // through DRAIN/BIAS/HOLD and returns to 0 whenever the sequencer goes idle.
    dense_row_counter #(.W(RW)) u_row (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (nxt == IDLE),
        .load     ((state == IDLE) && (nxt == ACCUM)),
        .load_val ('0),
        .inc      ((state == ACCUM) && (nxt == ACCUM)),
        .last     (RW'(N_IN - 1)),
        .count    (row_addr),
        .tc       (row_tc)
    );

    dense_row_counter #(.W(DW)) u_drain (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (state != DRAIN),
        .load     (1'b0),
        .load_val ('0),
        .inc      (state == DRAIN),
        .last     (DW'(MAC_LAT - 1)),
        .count    (drn_cnt),
        .tc       (drn_tc)
    );

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
            bias_en   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            in_ready  <= (nxt == IDLE);
            mac_en    <= (nxt == ACCUM);
            mac_first <= (state == IDLE) && (nxt == ACCUM);
            bias_en   <= (nxt == BIAS);
            out_valid <= (nxt == HOLD);
            busy      <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Randomized self-checking bench for dense_seq_ctrl against a per-vector timeline model.
module tb_dense_seq_ctrl;

    localparam int N_IN    = 32;
    localparam int MAC_LAT = 2;
    localparam int RW      = $clog2(N_IN);
    localparam int LAT     = N_IN + MAC_LAT + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [RW-1:0] row_addr;
    logic          mac_en;
    logic          mac_first;
    logic          bias_en;
    logic          out_valid;
    logic          busy;

    int  errors = 0;
    int  checks = 0;
    time accept_t = 0;

    always #5 clk = ~clk;

    dense_seq_ctrl #(.N_IN(N_IN), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_addr  (row_addr),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .bias_en   (bias_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic test_reset();
        reset_n = 1'b0; abort = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mac_en, mac_first, bias_en, out_valid, busy} !== 6'b0 || row_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy,mac,first,bias,ov,busy=%b row=%0d, required 000000 row=0",
                     {in_ready, mac_en, mac_first, bias_en, out_valid, busy}, row_addr);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_edge1: in_ready=%b busy=%b, required in_ready=1 busy=0", in_ready, busy);
        end
        @(negedge clk);
    endtask

    // One vector: k counts negedge samples after the accept edge. Outputs seen at k
    // were set by edge accept+k-1. abort_at/reset_at < 0 disables those events.
    task automatic run_vector(input int hold, input int abort_at, input int reset_at);
        int   last_ov;
        int   e_row;
        logic [5:0] e_ctl;
        logic [5:0] a_ctl;
        last_ov = LAT + 1 + hold;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1; abort = 1'b0;
        @(posedge clk);
        accept_t = $time;
        for (int k = 1; k <= last_ov + 1; k++) begin
            @(negedge clk);
            a_ctl = {in_ready, mac_en, mac_first, bias_en, out_valid, busy};
            if (abort_at >= 0 && k == abort_at + 1) begin
                e_ctl = 6'b100000;
                e_row = 0;
            end else begin
                e_ctl = {k == last_ov + 1, k <= N_IN, k == 1, k == LAT,
                         (k >= LAT + 1) && (k <= last_ov), k <= last_ov};
                e_row = (k <= N_IN) ? k - 1 : ((k <= last_ov) ? N_IN - 1 : 0);
            end
            checks++;
            if (a_ctl !== e_ctl) begin
                errors++;
                $display("FAIL ctl_k%0d: rdy,mac,first,bias,ov,busy=%b, required %b", k, a_ctl, e_ctl);
            end
            checks++;
            if (row_addr !== RW'(e_row)) begin
                errors++;
                $display("FAIL row_k%0d: row_addr=%0d, required %0d", k, row_addr, e_row);
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                abort = 1'b0;
                return;
            end
            if (reset_at >= 0 && k == reset_at) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if ({in_ready, mac_en, mac_first, bias_en, out_valid, busy} !== 6'b0 || row_addr !== '0) begin
                    errors++;
                    $display("FAIL async_reset: ctl=%b row=%0d, required 000000 row=0",
                             {in_ready, mac_en, mac_first, bias_en, out_valid, busy}, row_addr);
                end
                repeat (2) @(negedge clk);
                in_valid = 1'b1;
                reset_n = 1'b1;
                @(posedge clk); #1;
                checks++;
                if (in_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_reset: in_ready=%b busy=%b, required 1 0", in_ready, busy);
                end
                @(negedge clk);
                return;
            end
            if (abort_at >= 0 && k == abort_at) abort = 1'b1;
            in_valid  = 1'($urandom);
            out_ready = (k < LAT + 1) ? 1'($urandom) : (k >= last_ov);
        end
    endtask

    task automatic test_full_vector();
        run_vector(0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_vector(10, -1, -1);
    endtask

    task automatic test_abort();
        run_vector(0, 18, -1);
        run_vector(0, -1, -1);
    endtask

    task automatic test_abort_idle();
        in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mac_en !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: busy=%b mac_en=%b in_ready=%b, required 0 0 1", busy, mac_en, in_ready);
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_drain();
        run_vector(0, -1, N_IN + 1);
        run_vector(0, -1, -1);
    endtask

    task automatic test_back_to_back();
        time prev_t;
        for (int i = 0; i < 3; i++) begin
            run_vector(0, -1, -1);
            if (i > 0) begin
                checks++;
                if ((accept_t - prev_t) != 370) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: cycles=%0d, required 37", i, (accept_t - prev_t) / 10);
                end
            end
            prev_t = accept_t;
        end
    endtask

    task automatic test_random_holds();
        for (int i = 0; i < 4; i++) run_vector(int'($urandom_range(0, 6)), -1, -1);
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_backpressure();
        test_abort();
        test_abort_idle();
        test_reset_drain();
        test_back_to_back();
        test_random_holds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
